// File: rtl/drive_sd_server.sv
// Sector-transfer server: arbitrates per-drive sd_rd/sd_wr requests and streams bytes between
// the backing store and the granted drive's buffer. Define DRIVE_SD_RR_EN for round-robin arbitration.
module drive_sd_server #(
   parameter int  DRIVES = 3,
   localparam int NDR    = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
   input  logic              clk_sys_i,
   input  logic              reset_n_i,
   input  logic [NDR*32-1:0] sd_lba_i,
   input  logic [NDR*6-1:0]  sd_blk_cnt_i,
   input  logic [NDR-1:0]    sd_rd_i,
   input  logic [NDR-1:0]    sd_wr_i,
   input  logic [NDR*8-1:0]  sd_buff_din_i,
   output logic [NDR-1:0]    sd_ack_o,
   output logic [13:0]       sd_buff_addr_o,
   output logic [7:0]        sd_buff_dout_o,
   output logic              sd_buff_wr_o,
   output logic [31:0]       mem_lba_o,
   output logic [8:0]        mem_offs_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              busy_o
);

   typedef enum logic [2:0] {
      IDLE, GRANT, RD_REQ, RD_NEXT, WR_ADDR, WR_CAP, WR_REQ, DONE
   } state_t;

   logic [31:0]    lba_a [NDR];
   logic [4:0]     blk_a [NDR];
   logic [7:0]     din_a [NDR];
   logic [NDR-1:0] unused_blk_msb;
   logic [NDR-1:0] req;

   for (genvar gi = 0; gi < NDR; gi++) begin : g_unpack
      assign lba_a[gi]          = sd_lba_i[gi*32 +: 32];
      assign blk_a[gi]          = sd_blk_cnt_i[gi*6 +: 5];
      assign unused_blk_msb[gi] = sd_blk_cnt_i[gi*6 + 5];
      assign din_a[gi]          = sd_buff_din_i[gi*8 +: 8];
   end
   assign req = sd_rd_i | sd_wr_i;

   state_t         state_q, state_d;
   logic [1:0]     g_q, g_d;
   logic           rd_q, rd_d;
   logic [31:0]    lba_q, lba_d;
   logic [4:0]     blk_q, blk_d;
   logic [13:0]    cnt_q, cnt_d;
   logic [NDR-1:0] ack_q, ack_d;
   logic [13:0]    addr_q, addr_d;
   logic [7:0]     dout_q, dout_d;
   logic           bwr_q, bwr_d;
   logic [31:0]    mlba_q, mlba_d;
   logic [8:0]     moffs_q, moffs_d;
   logic           mrd_q, mrd_d;
   logic           mwr_q, mwr_d;
   logic [7:0]     wdata_q, wdata_d;

   logic [1:0]  win;
   logic        win_rd;
   logic [31:0] win_lba;
   logic [4:0]  win_blk;
   logic [7:0]  din_g;
   logic        req_g;
   logic        last;

`ifdef DRIVE_SD_RR_EN
   logic [1:0] ptr_q;

   // Search begins one past the last grant; the pointer's own drive has lowest priority.
   always_comb begin
      win = 2'd0;
      for (int k = NDR; k >= 1; k--) begin
         if (req[(int'(ptr_q) + k) % NDR]) win = 2'((int'(ptr_q) + k) % NDR);
      end
   end

   always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
      if (!reset_n_i)                     ptr_q <= 2'(NDR - 1);
      else if (state_q == GRANT && |req)  ptr_q <= win;
   end
`else
   always_comb begin
      win = 2'd0;
      for (int k = NDR - 1; k >= 0; k--) begin
         if (req[k]) win = 2'(k);
      end
   end
`endif

   always_comb begin
      win_rd  = 1'b0;
      win_lba = '0;
      win_blk = '0;
      din_g   = '0;
      req_g   = 1'b0;
      for (int k = 0; k < NDR; k++) begin
         if (2'(k) == win) begin
            win_rd  = sd_rd_i[k];
            win_lba = lba_a[k];
            win_blk = blk_a[k];
         end
         if (2'(k) == g_q) begin
            din_g = din_a[k];
            req_g = req[k];
         end
      end
   end

   assign last = (cnt_q == {blk_q, 9'h1FF});

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      rd_d    = rd_q;
      lba_d   = lba_q;
      blk_d   = blk_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      bwr_d   = 1'b0;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: if (|req) state_d = GRANT;
         GRANT: begin
            if (|req) begin
               g_d     = win;
               rd_d    = win_rd;
               lba_d   = win_lba;
               blk_d   = win_blk;
               cnt_d   = '0;
               state_d = win_rd ? RD_REQ : WR_ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            if (mem_ready_i) begin
               dout_d  = mem_rdata_i;
               addr_d  = cnt_q;
               bwr_d   = 1'b1;
               state_d = RD_NEXT;
            end
         end
         RD_NEXT: begin
            if (last) state_d = DONE;
            else begin
               cnt_d   = cnt_q + 14'd1;
               state_d = RD_REQ;
            end
         end
         WR_ADDR: state_d = WR_CAP;
         WR_CAP: begin
            wdata_d = din_g;
            state_d = WR_REQ;
         end
         WR_REQ: begin
            if (mem_ready_i) begin
               if (last) state_d = DONE;
               else begin
                  cnt_d   = cnt_q + 14'd1;
                  state_d = WR_ADDR;
               end
            end
         end
         DONE: if (!req_g) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state values so they line up with the state they belong to.
      if (state_d == WR_ADDR) addr_d = cnt_d;
      mrd_d   = (state_d == RD_REQ);
      mwr_d   = (state_d == WR_REQ);
      mlba_d  = lba_d + {27'd0, cnt_d[13:9]};
      moffs_d = cnt_d[8:0];
      ack_d   = '0;
      if (state_d inside {RD_REQ, RD_NEXT, WR_ADDR, WR_CAP, WR_REQ}) begin
         for (int k = 0; k < NDR; k++) ack_d[k] = (2'(k) == g_d);
      end
   end

   always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         g_q     <= '0;
         rd_q    <= 1'b0;
         lba_q   <= '0;
         blk_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         bwr_q   <= 1'b0;
         mlba_q  <= '0;
         moffs_q <= '0;
         mrd_q   <= 1'b0;
         mwr_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         rd_q    <= rd_d;
         lba_q   <= lba_d;
         blk_q   <= blk_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         bwr_q   <= bwr_d;
         mlba_q  <= mlba_d;
         moffs_q <= moffs_d;
         mrd_q   <= mrd_d;
         mwr_q   <= mwr_d;
         wdata_q <= wdata_d;
      end
   end

   assign sd_ack_o       = ack_q;
   assign sd_buff_addr_o = addr_q;
   assign sd_buff_dout_o = dout_q;
   assign sd_buff_wr_o   = bwr_q;
   assign mem_lba_o      = mlba_q;
   assign mem_offs_o     = moffs_q;
   assign mem_rd_o       = mrd_q;
   assign mem_wr_o       = mwr_q;
   assign mem_wdata_o    = wdata_q;
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_drive_sd_server.sv
// Directed bench for drive_sd_server: scoreboard of expected transfers plus per-cycle output checking.
module tb_drive_sd_server;
   localparam int NDR = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NDR*32-1:0] sd_lba;
   logic [NDR*6-1:0]  sd_blk_cnt;
   logic [NDR-1:0]    sd_rd, sd_wr;
   logic [NDR*8-1:0]  sd_buff_din;
   logic [NDR-1:0]    sd_ack;
   logic [13:0]       sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic              sd_buff_wr;
   logic [31:0]       mem_lba;
   logic [8:0]        mem_offs;
   logic              mem_rd, mem_wr;
   logic [7:0]        mem_wdata, mem_rdata;
   logic              mem_ready;
   logic              busy;

   always #5 clk = ~clk;

   drive_sd_server #(.DRIVES(NDR)) dut (
      .clk_sys_i(clk), .reset_n_i(reset_n),
      .sd_lba_i(sd_lba), .sd_blk_cnt_i(sd_blk_cnt),
      .sd_rd_i(sd_rd), .sd_wr_i(sd_wr), .sd_buff_din_i(sd_buff_din),
      .sd_ack_o(sd_ack), .sd_buff_addr_o(sd_buff_addr), .sd_buff_dout_o(sd_buff_dout),
      .sd_buff_wr_o(sd_buff_wr), .mem_lba_o(mem_lba), .mem_offs_o(mem_offs),
      .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .busy_o(busy)
   );

   typedef struct {
      int          drv;
      bit          rd;
      logic [31:0] lba;
      logic [5:0]  blk;
   } xfer_t;

   xfer_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   bit    stall_mode = 1'b0;

   // Storage returns a byte derived from its block/offset; drive k's buffer holds addr ^ 0x5A ^ k.
   function automatic logic [7:0] rdf(logic [31:0] l, logic [8:0] o);
      return o[7:0] + l[7:0] - 8'h10;
   endfunction

   function automatic logic [7:0] bufv(int k, logic [13:0] a);
      return a[7:0] ^ 8'h5A ^ 8'(k);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(int k, bit rd, bit wr, logic [31:0] lba, logic [5:0] blk);
      sd_lba[k*32 +: 32]   = lba;
      sd_blk_cnt[k*6 +: 6] = blk;
      sd_rd[k] = rd;
      sd_wr[k] = wr;
   endtask

   task automatic drop(int k);
      sd_rd[k] = 1'b0;
      sd_wr[k] = 1'b0;
   endtask

   task automatic push(int k, bit rd, logic [31:0] lba, logic [5:0] blk);
      xfer_t x;
      x.drv = k; x.rd = rd; x.lba = lba; x.blk = blk;
      exp_q.push_back(x);
   endtask

   task automatic wait_ack(bit level, int limit, string name);
      int n = 0;
      while (((sd_ack != 0) != level) && n < limit) begin
         tick(1);
         n++;
      end
      chk(name, 64'(sd_ack != 0), 64'(level));
   endtask

   task automatic reset_chk(string name);
      chk({name, "_ctl"}, {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_rd, mem_wr, mem_wdata, busy}, 0);
      chk({name, "_mem"}, {mem_lba, mem_offs}, 0);
   endtask

   // Storage and drive-buffer models: 1-cycle synchronous buffer read, optional random stalls.
   initial begin
      logic [13:0] addr_s;
      int          stall_cnt;
      stall_cnt   = 0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      sd_buff_din = '0;
      forever begin
         @(negedge clk);
         addr_s = sd_buff_addr;
         @(posedge clk);
         #1;
         for (int k = 0; k < NDR; k++) sd_buff_din[k*8 +: 8] = bufv(k, addr_s);
         if (!stall_mode) begin
            mem_ready = 1'b1;
         end else if (stall_cnt == 0) begin
            mem_ready = 1'b1;
            stall_cnt = $urandom_range(0, 5);
         end else begin
            mem_ready = 1'b0;
            stall_cnt--;
         end
         mem_rdata = rdf(mem_lba, mem_offs);
      end
   end

   // Compare process: tracks the active transfer and checks every byte against the expected stream.
   initial begin
      xfer_t       cur;
      bit          active = 1'b0;
      int          e = 0;
      int          cyc = 0;
      int          last_cyc = 0;
      bit          prev_rd_wait = 1'b0, prev_wr_wait = 1'b0;
      logic [31:0] prev_lba, el;
      logic [8:0]  prev_offs;
      int          len;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            active = 1'b0;
            prev_rd_wait = 1'b0;
            prev_wr_wait = 1'b0;
            continue;
         end
         chk("ack_onehot", 64'($countones(sd_ack) <= 1), 1);
         chk("rd_wr_excl", 64'(mem_rd && mem_wr), 0);
         if (prev_rd_wait) chk("rd_stable", {mem_rd, mem_lba, mem_offs}, {1'b1, prev_lba, prev_offs});
         if (prev_wr_wait) chk("wr_stable", {mem_wr, mem_lba, mem_offs}, {1'b1, prev_lba, prev_offs});
         if (!active) begin
            if (sd_ack != 0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", 64'(sd_ack), 0);
               end else begin
                  cur = exp_q.pop_front();
                  active = 1'b1;
                  e = 0;
                  chk("grant_drive", 64'(sd_ack), 64'(1 << cur.drv));
               end
            end
            if (!active) chk("no_strobe_idle", 64'(sd_buff_wr || mem_rd || mem_wr), 0);
         end
         if (active) begin
            len = (int'(cur.blk[4:0]) + 1) * 512;
            el  = cur.lba + 32'(e / 512);
            if (sd_ack == 0) begin
               chk("xfer_len", 64'(e), 64'(len));
               active = 1'b0;
            end else begin
               chk("ack_held", 64'(sd_ack), 64'(1 << cur.drv));
               if (cur.rd) begin
                  chk("no_mem_wr_on_read", 64'(mem_wr), 0);
                  if (mem_rd && mem_ready) chk("rd_addr", {mem_lba, mem_offs}, {el, 9'(e % 512)});
                  if (sd_buff_wr) begin
                     chk("rd_byte", {sd_buff_addr, sd_buff_dout}, {14'(e), rdf(el, 9'(e % 512))});
                     if (!stall_mode && e > 0) chk("rd_gap", 64'(cyc - last_cyc), 2);
                     last_cyc = cyc;
                     e++;
                  end
               end else begin
                  chk("no_strobe_on_write", 64'(sd_buff_wr || mem_rd), 0);
                  if (mem_wr && mem_ready) begin
                     chk("wr_byte", {mem_lba, mem_offs, mem_wdata}, {el, 9'(e % 512), bufv(cur.drv, 14'(e))});
                     if (!stall_mode && e > 0) chk("wr_gap", 64'(cyc - last_cyc), 3);
                     last_cyc = cyc;
                     e++;
                  end
               end
            end
         end
         prev_rd_wait = mem_rd && !mem_ready;
         prev_wr_wait = mem_wr && !mem_ready;
         prev_lba     = mem_lba;
         prev_offs    = mem_offs;
      end
   end

   initial begin
      int order[$];
      int rer[$];
      int n;
      reset_n    = 1'b0;
      sd_lba     = '0;
      sd_blk_cnt = '0;
      sd_rd      = '0;
      sd_wr      = '0;
      tick(3);
      reset_chk("reset_state");
      reset_n = 1'b1;
      tick(2);

      // Drive 1 read, single block, grant latency and a pinned byte.
      push(1, 1'b1, 32'h10, 6'd0);
      req(1, 1'b1, 1'b0, 32'h10, 6'd0);
      tick(1);
      chk("t1_ack_lat1", {sd_ack, busy}, {3'b000, 1'b1});
      tick(1);
      chk("t1_ack_lat2", {sd_ack, mem_rd}, {3'b010, 1'b1});
      n = 0;
      while (!(sd_buff_wr && sd_buff_addr == 14'h37) && n < 2000) begin tick(1); n++; end
      chk("t1_pin", {sd_buff_addr, sd_buff_dout, mem_lba}, {14'h37, 8'h37, 32'h10});
      wait_ack(1'b0, 4000, "t1_ack_fall");
      tick(3);
      chk("t1_done_hold", 64'(busy), 1);
      drop(1);
      tick(1);
      chk("t1_idle", 64'(busy), 0);

      // Drive 0 write, two blocks (bit 5 of blk_cnt set and ignored), request dropped mid-way.
      push(0, 1'b0, 32'h200, 6'h21);
      req(0, 1'b0, 1'b1, 32'h200, 6'h21);
      wait_ack(1'b1, 20, "t2_ack_rise");
      n = 0;
      while (!(mem_wr && sd_buff_addr == 14'd513) && n < 4000) begin tick(1); n++; end
      chk("t2_pin", {mem_lba, mem_offs, mem_wdata}, {32'h201, 9'd1, 8'h5B});
      drop(0);
      wait_ack(1'b0, 8000, "t2_ack_fall");
      tick(1);
      chk("t2_idle", 64'(busy), 0);

      // Drive 2 read with random storage stalls.
      stall_mode = 1'b1;
      push(2, 1'b1, 32'h1234_5678, 6'd0);
      req(2, 1'b1, 1'b0, 32'h1234_5678, 6'd0);
      wait_ack(1'b1, 20, "t3_ack_rise");
      wait_ack(1'b0, 8000, "t3_ack_fall");
      drop(2);
      tick(1);
      stall_mode = 1'b0;
      chk("t3_idle", 64'(busy), 0);

      // Reset in the middle of a read; transfer restarts from byte 0.
      push(1, 1'b1, 32'h40, 6'd0);
      req(1, 1'b1, 1'b0, 32'h40, 6'd0);
      n = 0;
      while (!(sd_buff_wr && sd_buff_addr == 14'd200) && n < 2000) begin tick(1); n++; end
      chk("t4_reach_200", 64'(sd_buff_addr), 200);
      reset_n = 1'b0;
      #1;
      reset_chk("t4_reset_now");
      tick(2);
      reset_chk("t4_reset_hold");
      push(1, 1'b1, 32'h40, 6'd0);
      reset_n = 1'b1;
      wait_ack(1'b1, 20, "t4_ack_rise");
      n = 0;
      while (!sd_buff_wr && n < 50) begin tick(1); n++; end
      chk("t4_restart_addr", {sd_buff_wr, sd_buff_addr}, {1'b1, 14'd0});
      wait_ack(1'b0, 4000, "t4_ack_fall");
      drop(1);
      tick(1);

      // Both rd and wr on drive 2: read wins, LBA wraps into block 2, DONE waits for both to drop.
      push(2, 1'b1, 32'hFFFF_FFFF, 6'd1);
      req(2, 1'b1, 1'b1, 32'hFFFF_FFFF, 6'd1);
      wait_ack(1'b1, 20, "t5_ack_rise");
      n = 0;
      while (!(sd_buff_wr && sd_buff_addr == 14'd600) && n < 4000) begin tick(1); n++; end
      chk("t5_pin", {sd_buff_dout, mem_lba}, {8'h48, 32'h0});
      wait_ack(1'b0, 4000, "t5_ack_fall");
      tick(3);
      chk("t5_done_hold", 64'(busy), 1);
      sd_rd[2] = 1'b0;
      tick(3);
      chk("t5_done_hold_wr", 64'(busy), 1);
      sd_wr[2] = 1'b0;
      tick(1);
      chk("t5_idle", 64'(busy), 0);

      // Arbitration among drives 0, 1, 2 with drive 0 re-requesting.
`ifdef DRIVE_SD_RR_EN
      order = '{0, 1, 2, 0};
      rer   = '{1, 0, 0, 0};
`else
      order = '{0, 0, 0, 1, 2};
      rer   = '{1, 1, 0, 0, 0};
`endif
      foreach (order[r]) push(order[r], 1'b1, 32'h100 * order[r] + 32'h10, 6'd0);
      for (int k = 0; k < NDR; k++) req(k, 1'b1, 1'b0, 32'h100 * k + 32'h10, 6'd0);
      foreach (order[r]) begin
         wait_ack(1'b1, 20, "t6_ack_rise");
         wait_ack(1'b0, 4000, "t6_ack_fall");
         drop(order[r]);
         tick(1);
         if (rer[r] != 0) req(order[r], 1'b1, 1'b0, 32'h100 * order[r] + 32'h10, 6'd0);
      end
      tick(3);
      chk("t6_all_done", {64'(exp_q.size()), 64'(busy)}, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
